// File: rtl/led_gui_key_ctrl.sv
// Key front-end for the LED GUI: synchronise, debounce, arbitrate and lock out four
// active-low push-buttons, emitting one-hot single-cycle config_sig pulses.
// Define LED_GUI_KEY_REPEAT_EN to add auto-repeat on the up/down keys.
module led_gui_key_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_PER   = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic [3:0] config_sig,
  output logic       key_busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
`ifdef LED_GUI_KEY_REPEAT_EN
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam int DLY_W = $clog2(REPEAT_DLY);
  localparam int PER_W = $clog2(REPEAT_PER);
  localparam int RPT_W = (DLY_W > PER_W) ? DLY_W : PER_W;
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);
`endif

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] key_stb;
  logic [3:0] key_stb_d;
  logic [3:0] press;

  // Keys are inverted on entry so every internal vector is active-high "pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= ~key_in;
      sync2 <= sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [DB_W-1:0] db_cnt;
      logic            stb_bit;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_cnt  <= '0;
          stb_bit <= 1'b0;
        end else if (sync2[gi] == stb_bit) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          stb_bit <= sync2[gi];
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end

      assign key_stb[gi] = stb_bit;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_stb_d <= 4'b0000;
    end else begin
      key_stb_d <= key_stb;
    end
  end

  assign press = key_stb & ~key_stb_d;

  logic [1:0] win_idx;
  logic [3:0] win_oh;
  logic [3:0] owner_oh;
  logic [1:0] state;
  logic [1:0] owner;

  always_comb begin
    win_idx = 2'd0;
    if (press[3])      win_idx = 2'd3;
    else if (press[2]) win_idx = 2'd2;
    else if (press[1]) win_idx = 2'd1;
    win_oh = 4'b0001 << win_idx;
  end

  assign owner_oh = 4'b0001 << owner;

`ifdef LED_GUI_KEY_REPEAT_EN
  logic [RPT_W-1:0] rpt_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 2'd0;
      config_sig <= 4'b0000;
      key_busy   <= 1'b0;
`ifdef LED_GUI_KEY_REPEAT_EN
      rpt_cnt    <= '0;
`endif
    end else begin
      config_sig <= 4'b0000;
      key_busy   <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          // Losers of a simultaneous press are dropped, not queued.
          if (|press) begin
            config_sig <= win_oh;
            owner      <= win_idx;
            state      <= ST_HOLD;
`ifdef LED_GUI_KEY_REPEAT_EN
            rpt_cnt    <= '0;
`endif
          end
        end
        ST_HOLD: begin
          if (!key_stb[owner]) begin
            state <= ST_IDLE;
          end
`ifdef LED_GUI_KEY_REPEAT_EN
          else if (owner[1]) begin
            if (rpt_cnt == DLY_LAST) begin
              config_sig <= owner_oh;
              rpt_cnt    <= '0;
              state      <= ST_REPEAT;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
`endif
        end
`ifdef LED_GUI_KEY_REPEAT_EN
        ST_REPEAT: begin
          // Release is checked first so it beats a coincident repeat expiry.
          if (!key_stb[owner]) begin
            state <= ST_IDLE;
          end else if (rpt_cnt == PER_LAST) begin
            config_sig <= owner_oh;
            rpt_cnt    <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
